// File: rtl/spi_m_pkg.sv
// Shared types and constants for the spi_m SPI Mode 1 master.
// Optional feature macro: SPI_M_FRAME_CLOSE_EN (adds the CLOSE_H/CLOSE_L states).
package spi_pkg;

    localparam int   SPI_DATA_W    = 8;
    localparam logic SPI_IDLE_SS   = 1'b1;
    localparam logic SPI_IDLE_SCLK = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_HIGH,
        ST_LOW,
`ifdef SPI_M_FRAME_CLOSE_EN
        ST_CLOSE_H,
        ST_CLOSE_L,
`endif
        ST_TRAIL
    } spi_m_state_t;

endpackage

// File: rtl/spi_m_if.sv
// Bus bundle between the spi_m controller side (master modport) and its
// user/responder side (slave modport).
interface spi_m_if
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic              ss;

    modport master (
        input  start, tx_data, miso,
        output busy, done, rx_data, sclk, mosi, ss
    );

    modport slave (
        output start, tx_data, miso,
        input  busy, done, rx_data, sclk, mosi, ss
    );
endinterface

// File: rtl/spi_m_tick.sv
// Half-period down-counter for spi_m: tick is high when the count has
// expired; reload restarts a CLK_DIV-cycle interval.
module spi_m_tick
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: reload wins, otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);
endmodule

// File: rtl/spi_m.sv
// SPI Mode 1 (CPOL=0, CPHA=1) master, MSB first, sclk from a half-period divider.
// Optional feature macro: SPI_M_FRAME_CLOSE_EN appends one extra sclk pulse per frame.
module spi_m
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = SPI_DATA_W
) (
    input logic    clk,
    input logic    rst,
    spi_m_if.master bus
);
    localparam int BW = $clog2(DATA_W + 1);

    spi_m_state_t      state_q, state_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              sclk_q, sclk_d;
    logic              ss_q, ss_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick, reload, rise;

    spi_m_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .reload (reload),
        .tick   (tick)
    );

    // Next-state and pin logic; every state lasts one divider interval.
    always_comb begin
        state_d = state_q;
        tx_sh_d = tx_sh_q;
        rx_sh_d = rx_sh_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        ss_d    = ss_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        reload  = 1'b0;
        rise    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    tx_sh_d = bus.tx_data;
                    bit_d   = BW'(DATA_W);
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    reload  = 1'b1;
                    state_d = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (tick) begin
                    rise    = 1'b1;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    reload  = 1'b1;
                    sclk_d  = 1'b0;
                    rx_sh_d = {rx_sh_q[DATA_W-2:0], bus.miso};
                    bit_d   = bit_q - 1'b1;
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (tick) begin
                    reload = 1'b1;
                    if (bit_q != '0) begin
                        rise    = 1'b1;
                        state_d = ST_HIGH;
                    end else begin
`ifdef SPI_M_FRAME_CLOSE_EN
                        sclk_d  = 1'b1;
                        state_d = ST_CLOSE_H;
`else
                        state_d = ST_TRAIL;
`endif
                    end
                end
            end
`ifdef SPI_M_FRAME_CLOSE_EN
            ST_CLOSE_H: begin
                if (tick) begin
                    reload  = 1'b1;
                    sclk_d  = 1'b0;
                    state_d = ST_CLOSE_L;
                end
            end
            ST_CLOSE_L: begin
                if (tick) begin
                    reload  = 1'b1;
                    state_d = ST_TRAIL;
                end
            end
`endif
            ST_TRAIL: begin
                if (tick) begin
                    ss_d    = SPI_IDLE_SS;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    rx_d    = rx_sh_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Shared sclk rising-edge action from LEAD and LOW.
        if (rise) begin
            reload  = 1'b1;
            sclk_d  = 1'b1;
            mosi_d  = tx_sh_q[DATA_W-1];
            tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
        end
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tx_sh_q <= '0;
            rx_sh_q <= '0;
            rx_q    <= '0;
            bit_q   <= '0;
            sclk_q  <= SPI_IDLE_SCLK;
            ss_q    <= SPI_IDLE_SS;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_sh_q <= tx_sh_d;
            rx_sh_q <= rx_sh_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            ss_q    <= ss_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.sclk    = sclk_q;
    assign bus.ss      = ss_q;
    assign bus.mosi    = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_q;
endmodule
